sa_job_scheduler: RTL and testbench

Controller that shares the 16x16 systolic-array wrapper between two requesters, for example a Q·Kᵀ engine and an attention·V engine. Each grant runs one job of N K-dimension tiles, 16 deep each, so 8 tiles cover a 128-deep product. For every tile the block clears the array, pulses its start, waits for result-valid and drives the tile index for the operand muxes. It also produces first/last qualifiers for the downstream accumulator and aborts jobs whose tile never completes.

---
 rtl/sa_job_if.sv | 29 ++
 rtl/sa_job_scheduler.sv | 137 +++++++++++++
 tb/tb_sa_job_scheduler.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/sa_job_if.sv
// Bundle shared by the systolic-array job scheduler, its two requesters and the array.
// The master side is the scheduler; the slave side groups the requesters and the array.
interface sa_job_if #(
    parameter int unsigned TILE_W = 4
);
    logic [1:0]        req;
    logic [TILE_W-1:0] ntile0;
    logic [TILE_W-1:0] ntile1;
    logic              sa_out_vld;
    logic [1:0]        gnt;
    logic [1:0]        done;
    logic [1:0]        err;
    logic              sa_clr;
    logic              sa_start;
    logic [TILE_W-1:0] k_tile;
    logic              acc_first_c;
    logic              acc_last_c;
    logic              busy;

    modport master (
        input  req, ntile0, ntile1, sa_out_vld,
        output gnt, done, err, sa_clr, sa_start, k_tile, acc_first_c, acc_last_c, busy
    );

    modport slave (
        output req, ntile0, ntile1, sa_out_vld,
        input  gnt, done, err, sa_clr, sa_start, k_tile, acc_first_c, acc_last_c, busy
    );
endinterface

// File: rtl/sa_job_scheduler.sv
// Shares one 16x16 systolic array between two requesters: round-robin grant, per-tile
// clear/start/wait sequencing, accumulator first/last qualifiers and a per-tile watchdog.
module sa_job_scheduler #(
    parameter int unsigned TILE_W  = 4,
    parameter int unsigned TO_W    = 11,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic     clk,
    input  logic     rst,
    sa_job_if.master bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4,
        ABORT = 3'd5
    } state_t;

    state_t            state, state_n;
    logic              owner, owner_n;
    logic              ptr, ptr_n;
    logic [TILE_W-1:0] cnt, cnt_n;
    logic [TILE_W-1:0] tile, tile_n;
    logic [TO_W-1:0]   wdog, wdog_n;

    logic [1:0]        gnt_q, gnt_n;
    logic [1:0]        done_q, done_n;
    logic [1:0]        err_q, err_n;
    logic              clr_q, clr_n;
    logic              start_q, start_n;
    logic              busy_q, busy_n;

    logic              last_tile;
    logic              winner;
    logic [TILE_W-1:0] req_cnt;
    logic [1:0]        owner_oh_n;

    // Pointer wins only on a tie; a lone request wins outright.
    assign winner    = (bus.req == 2'b11) ? ptr : bus.req[1];
    assign req_cnt   = winner ? bus.ntile1 : bus.ntile0;
    assign last_tile = (tile == cnt - TILE_W'(1));

    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        cnt_n   = cnt;
        tile_n  = tile;
        wdog_n  = wdog;
        unique case (state)
            IDLE: begin
                if (|bus.req) begin
                    owner_n = winner;
                    cnt_n   = (req_cnt == '0) ? TILE_W'(1) : req_cnt;
                    tile_n  = '0;
                    state_n = CLR;
                end
            end
            CLR:   state_n = START;
            START: begin
                wdog_n  = '0;
                state_n = WAIT;
            end
            WAIT: begin
                // A valid beats a same-cycle timeout.
                if (bus.sa_out_vld) begin
                    if (last_tile) begin
                        state_n = DONE;
                    end else begin
                        tile_n  = tile + TILE_W'(1);
                        state_n = CLR;
                    end
                end else if (wdog == TO_W'(TIMEOUT - 1)) begin
                    state_n = ABORT;
                end else begin
                    wdog_n = wdog + TO_W'(1);
                end
            end
            DONE, ABORT: begin
                ptr_n   = ~owner;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        owner_oh_n = owner_n ? 2'b10 : 2'b01;
        gnt_n      = (state_n == CLR || state_n == START || state_n == WAIT) ? owner_oh_n : 2'b00;
        done_n     = (state_n == DONE)  ? owner_oh_n : 2'b00;
        err_n      = (state_n == ABORT) ? owner_oh_n : 2'b00;
        clr_n      = (state_n == CLR);
        start_n    = (state_n == START);
        busy_n     = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= 1'b0;
            ptr     <= 1'b0;
            cnt     <= '0;
            tile    <= '0;
            wdog    <= '0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            err_q   <= 2'b00;
            clr_q   <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_n;
            owner   <= owner_n;
            ptr     <= ptr_n;
            cnt     <= cnt_n;
            tile    <= tile_n;
            wdog    <= wdog_n;
            gnt_q   <= gnt_n;
            done_q  <= done_n;
            err_q   <= err_n;
            clr_q   <= clr_n;
            start_q <= start_n;
            busy_q  <= busy_n;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.sa_clr      = clr_q;
    assign bus.sa_start    = start_q;
    assign bus.busy        = busy_q;
    assign bus.k_tile      = tile;
    // Accumulator qualifiers ride on the valid itself, so they stay combinational.
    assign bus.acc_first_c = (state == WAIT) && bus.sa_out_vld && (tile == '0);
    assign bus.acc_last_c  = (state == WAIT) && bus.sa_out_vld && last_tile;
endmodule

// File: tb/tb_sa_job_scheduler.sv
// Bench for sa_job_scheduler: scenario tasks drive jobs and compare against a job-level
// model (tie-break pointer, effective tile count, fixed pipeline latencies).
module tb_sa_job_scheduler;
    localparam int unsigned TW = 4;
    localparam int unsigned TOW = 11;
    localparam int TO = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   exp_ptr = 0;

    sa_job_if #(.TILE_W(TW)) bus ();

    sa_job_scheduler #(.TILE_W(TW), .TO_W(TOW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Runs one job starting from an IDLE negedge. hang_tile never gets a valid;
    // rst_tile gets a synchronous reset in its first WAIT cycle.
    task automatic run_job(input logic [1:0] reqs, input logic [3:0] n0, input logic [3:0] n1,
                           input int lat_lo, input int lat_hi, input int hang_tile, input int rst_tile);
        int win, n, lat;
        logic [1:0] oh;
        logic ok;
        win = (reqs == 2'b11) ? exp_ptr : (reqs[1] ? 1 : 0);
        n   = (win == 1) ? int'(n1) : int'(n0);
        if (n == 0) n = 1;
        oh  = (win == 1) ? 2'b10 : 2'b01;
        bus.req = reqs;
        bus.ntile0 = n0;
        bus.ntile1 = n1;
        @(negedge clk);
        total++;
        if (bus.gnt !== oh || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL grant: gnt=%b busy=%b, want gnt=%b busy=1", bus.gnt, bus.busy, oh);
        end
        bus.ntile0 = 4'($urandom);
        bus.ntile1 = 4'($urandom);
        for (int i = 0; i < n; i++) begin
            total++;
            if (bus.sa_clr !== 1'b1 || bus.sa_start !== 1'b0 || bus.k_tile !== 4'(i) || bus.gnt !== oh) begin
                bad++;
                $display("FAIL clr tile %0d: clr=%b start=%b k=%0d gnt=%b, want clr=1 start=0 k=%0d gnt=%b",
                         i, bus.sa_clr, bus.sa_start, bus.k_tile, bus.gnt, i, oh);
            end
            @(negedge clk);
            total++;
            if (bus.sa_clr !== 1'b0 || bus.sa_start !== 1'b1 || bus.k_tile !== 4'(i)) begin
                bad++;
                $display("FAIL start tile %0d: clr=%b start=%b k=%0d, want clr=0 start=1 k=%0d",
                         i, bus.sa_clr, bus.sa_start, bus.k_tile, i);
            end
            if (i == rst_tile) begin
                @(negedge clk);
                rst = 1'b1;
                bus.sa_out_vld = 1'b1;
                @(negedge clk);
                #1;
                total++;
                if (bus.gnt !== 2'b00 || bus.done !== 2'b00 || bus.err !== 2'b00 || bus.sa_clr !== 1'b0 ||
                    bus.sa_start !== 1'b0 || bus.k_tile !== 4'd0 || bus.busy !== 1'b0 ||
                    bus.acc_first_c !== 1'b0 || bus.acc_last_c !== 1'b0) begin
                    bad++;
                    $display("FAIL mid-job reset: gnt=%b done=%b err=%b clr=%b start=%b k=%0d busy=%b af=%b al=%b, want all 0",
                             bus.gnt, bus.done, bus.err, bus.sa_clr, bus.sa_start, bus.k_tile, bus.busy,
                             bus.acc_first_c, bus.acc_last_c);
                end
                rst = 1'b0;
                bus.sa_out_vld = 1'b0;
                bus.req = 2'b00;
                exp_ptr = 0;
                return;
            end
            if (i == hang_tile) begin
                ok = 1'b1;
                for (int k = 1; k <= TO; k++) begin
                    @(negedge clk);
                    if (bus.err !== 2'b00 || bus.done !== 2'b00 || bus.gnt !== oh) ok = 1'b0;
                end
                total++;
                if (!ok) begin
                    bad++;
                    $display("FAIL watchdog early: err/done raised or gnt lost before %0d cycles", TO + 1);
                end
                @(negedge clk);
                total++;
                if (bus.err !== oh || bus.done !== 2'b00 || bus.gnt !== 2'b00) begin
                    bad++;
                    $display("FAIL watchdog abort: err=%b done=%b gnt=%b, want err=%b done=00 gnt=00",
                             bus.err, bus.done, bus.gnt, oh);
                end
                bus.req = reqs & ~oh;
                exp_ptr = 1 - win;
                @(negedge clk);
                total++;
                if (bus.busy !== 1'b0 || bus.err !== 2'b00) begin
                    bad++;
                    $display("FAIL after abort: busy=%b err=%b, want busy=0 err=00", bus.busy, bus.err);
                end
                return;
            end
            lat = $urandom_range(lat_hi, lat_lo);
            ok = 1'b1;
            for (int k = 1; k < lat; k++) begin
                @(negedge clk);
                if (bus.sa_clr !== 1'b0 || bus.sa_start !== 1'b0 || bus.acc_first_c !== 1'b0 ||
                    bus.acc_last_c !== 1'b0 || bus.k_tile !== 4'(i) || bus.gnt !== oh ||
                    bus.done !== 2'b00 || bus.err !== 2'b00) ok = 1'b0;
            end
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL wait tile %0d: outputs disturbed while waiting %0d cycles", i, lat);
            end
            @(negedge clk);
            bus.sa_out_vld = 1'b1;
            #1;
            total++;
            if (bus.acc_first_c !== (i == 0) || bus.acc_last_c !== (i == n - 1) || bus.k_tile !== 4'(i)) begin
                bad++;
                $display("FAIL qualifiers tile %0d/%0d: first=%b last=%b k=%0d, want first=%b last=%b k=%0d",
                         i, n, bus.acc_first_c, bus.acc_last_c, bus.k_tile, (i == 0), (i == n - 1), i);
            end
            @(negedge clk);
            bus.sa_out_vld = 1'b0;
        end
        total++;
        if (bus.done !== oh || bus.gnt !== 2'b00 || bus.err !== 2'b00 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL done pulse: done=%b gnt=%b err=%b busy=%b, want done=%b gnt=00 err=00 busy=1",
                     bus.done, bus.gnt, bus.err, bus.busy, oh);
        end
        bus.req = reqs & ~oh;
        exp_ptr = 1 - win;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 2'b00 || bus.gnt !== 2'b00) begin
            bad++;
            $display("FAIL idle gap: busy=%b done=%b gnt=%b, want busy=0 done=00 gnt=00",
                     bus.busy, bus.done, bus.gnt);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req = 2'b00;
        bus.sa_out_vld = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.gnt !== 2'b00 || bus.done !== 2'b00 || bus.err !== 2'b00 || bus.sa_clr !== 1'b0 ||
            bus.sa_start !== 1'b0 || bus.k_tile !== 4'd0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset: gnt=%b done=%b err=%b clr=%b start=%b k=%0d busy=%b, want all 0",
                     bus.gnt, bus.done, bus.err, bus.sa_clr, bus.sa_start, bus.k_tile, bus.busy);
        end
        rst = 1'b0;
        exp_ptr = 0;
    endtask

    task automatic test_single_tile();
        run_job(2'b01, 4'd1, 4'd5, 40, 40, -1, -1);
    endtask

    task automatic test_eight_tiles();
        run_job(2'b01, 4'd8, 4'd3, 1, 12, -1, -1);
    endtask

    task automatic test_arbitration();
        test_reset();
        for (int j = 0; j < 4; j++) run_job(2'b11, 4'd2, 4'd2, 1, 6, -1, -1);
    endtask

    task automatic test_timeout();
        run_job(2'b01, 4'd2, 4'd2, 1, 5, 0, -1);
        run_job(2'b10, 4'd2, 4'd2, 1, 5, -1, -1);
        run_job(2'b10, 4'd3, 4'd1, TO, TO, -1, -1);
    endtask

    task automatic test_reset_mid_job();
        run_job(2'b01, 4'd8, 4'd8, 1, 4, -1, 3);
        @(negedge clk);
        bus.sa_out_vld = 1'b1;
        #1;
        total++;
        if (bus.acc_first_c !== 1'b0 || bus.acc_last_c !== 1'b0) begin
            bad++;
            $display("FAIL stray valid: first=%b last=%b, want 0 0", bus.acc_first_c, bus.acc_last_c);
        end
        @(negedge clk);
        bus.sa_out_vld = 1'b0;
        total++;
        if (bus.done !== 2'b00 || bus.gnt !== 2'b00 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL stray valid aftermath: done=%b gnt=%b busy=%b, want 00 00 0",
                     bus.done, bus.gnt, bus.busy);
        end
    endtask

    task automatic test_zero_count();
        run_job(2'b10, 4'd4, 4'd0, 3, 9, -1, -1);
    endtask

    task automatic test_random();
        logic [1:0] r;
        for (int j = 0; j < 15; j++) begin
            r = 2'($urandom_range(3, 1));
            run_job(r, 4'($urandom_range(8, 0)), 4'($urandom_range(8, 0)), 1, 20,
                    ($urandom_range(7, 0) == 0) ? 0 : -1, -1);
        end
    endtask

    initial begin
        bus.req = 2'b00;
        bus.ntile0 = 4'd0;
        bus.ntile1 = 4'd0;
        bus.sa_out_vld = 1'b0;
        test_reset();
        test_single_tile();
        test_eight_tiles();
        test_arbitration();
        test_timeout();
        test_reset_mid_job();
        test_zero_count();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
